// File: rtl/guitar_input_capture_if.sv
// ---------------------------------------------------------------------------
// guitar_input_capture_if
//
// Bundles the two guitar controllers' raw button lines together with the
// conditioned status word that the register file loads into r29.
//
// Signals:
//   p1_fret[4:0], p1_strum_up, p1_strum_down, p1_start : player 1 raw buttons
//   p2_fret[4:0], p2_strum_up, p2_strum_down, p2_start : player 2 raw buttons
//   external_inputs[31:0] : registered status word (r29 image)
//   tick_pulse            : one-cycle frame tick strobe
//
// Modports:
//   master : the controller side; drives buttons, observes the status word
//   slave  : the capture block; reads buttons, drives the status word
// ---------------------------------------------------------------------------
interface guitar_input_capture_if;

    logic [4:0]  p1_fret;
    logic        p1_strum_up;
    logic        p1_strum_down;
    logic        p1_start;
    logic [4:0]  p2_fret;
    logic        p2_strum_up;
    logic        p2_strum_down;
    logic        p2_start;
    logic [31:0] external_inputs;
    logic        tick_pulse;

    modport master (
        output p1_fret, p1_strum_up, p1_strum_down, p1_start,
        output p2_fret, p2_strum_up, p2_strum_down, p2_start,
        input  external_inputs, tick_pulse
    );

    modport slave (
        input  p1_fret, p1_strum_up, p1_strum_down, p1_start,
        input  p2_fret, p2_strum_up, p2_strum_down, p2_start,
        output external_inputs, tick_pulse
    );

endinterface

// File: rtl/guitar_input_capture.sv
// ---------------------------------------------------------------------------
// guitar_input_capture
//
// Front-end conditioner for the two guitar controllers. Every raw button is
// synchronized through two flops and then debounced. Strum presses and frame
// ticks are counted with wrapping counters, so software polling r29 can spot
// new events by comparing against the previous value it saw.
//
// Ports:
//   clock        : single clock, all state changes on its rising edge
//   ctrl_reset_n : asynchronous active-low reset
//   bus          : slave side of guitar_input_capture_if (raw buttons in,
//                  external_inputs / tick_pulse out)
//
// Status word layout (external_inputs):
//   [4:0] p1 frets, [5] p1 strum level, [6] p1 start, [7] 0,
//   [11:8] p1 strum count, [16:12] p2 frets, [17] p2 strum level,
//   [18] p2 start, [19] 0, [23:20] p2 strum count, [31:24] tick count
// ---------------------------------------------------------------------------
module guitar_input_capture #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_CYCLES     = 833333
) (
    input logic                   clock,
    input logic                   ctrl_reset_n,
    guitar_input_capture_if.slave bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int TK_W = $clog2(TICK_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

    logic [15:0]     w_raw;
    logic [15:0]     r_s1;
    logic [15:0]     r_s2;
    logic [15:0]     r_stable;
    logic [15:0]     w_stableNext;
    logic [DB_W-1:0] r_dbCnt     [16];
    logic [DB_W-1:0] w_dbCntNext [16];
    logic            w_p1Rise;
    logic            w_p2Rise;
    logic [3:0]      r_p1Strums;
    logic [3:0]      r_p2Strums;
    logic [3:0]      w_p1StrumsNext;
    logic [3:0]      w_p2StrumsNext;
    logic [TK_W-1:0] r_prescale;
    logic [TK_W-1:0] w_prescaleNext;
    logic            w_tickWrap;
    logic [7:0]      r_tickCount;
    logic [7:0]      w_tickCountNext;
    logic [31:0]     r_word;
    logic [31:0]     w_wordNext;
    logic            r_tickPulse;

    // Flatten the sixteen raw buttons into one vector so synchronizers and
    // debouncers can be handled uniformly. Bits 4:0 p1 frets, 5 p1 up,
    // 6 p1 down, 7 p1 start, 12:8 p2 frets, 13 p2 up, 14 p2 down, 15 p2 start.
    assign w_raw = {bus.p2_start, bus.p2_strum_down, bus.p2_strum_up, bus.p2_fret,
                    bus.p1_start, bus.p1_strum_down, bus.p1_strum_up, bus.p1_fret};

    // Two-flop synchronizer for every raw input; the buttons are fully
    // asynchronous to our clock so nothing may look at them before r_s2.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Debouncer next state. A synchronized input must disagree with its
    // stable value for a full window of consecutive cycles before the
    // stable value follows it; any agreement in between restarts the window.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_stableNext[i] = r_stable[i];
            w_dbCntNext[i]  = '0;
            if (r_s2[i] != r_stable[i]) begin
                if (r_dbCnt[i] == DB_LAST) begin
                    w_stableNext[i] = r_s2[i];
                end else begin
                    w_dbCntNext[i] = r_dbCnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_stable <= '0;
            for (int i = 0; i < 16; i++) begin
                r_dbCnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stableNext;
            for (int i = 0; i < 16; i++) begin
                r_dbCnt[i] <= w_dbCntNext[i];
            end
        end
    end

    // Strum edge detection on the debounced values. Up and down rising on the
    // same edge are a single physical strum, so they are OR-ed into one event.
    // Counters use next-state values so the count lands in the same word as
    // the level change that caused it.
    always_comb begin
        w_p1Rise        = (w_stableNext[5]  & ~r_stable[5])  | (w_stableNext[6]  & ~r_stable[6]);
        w_p2Rise        = (w_stableNext[13] & ~r_stable[13]) | (w_stableNext[14] & ~r_stable[14]);
        w_p1StrumsNext  = r_p1Strums + {3'b000, w_p1Rise};
        w_p2StrumsNext  = r_p2Strums + {3'b000, w_p2Rise};
        w_tickWrap      = (r_prescale == TK_LAST);
        w_prescaleNext  = w_tickWrap ? '0 : r_prescale + TK_W'(1);
        w_tickCountNext = r_tickCount + {7'd0, w_tickWrap};
    end

    // Pack the r29 image from next-state values so every field changes on
    // the very edge its underlying state changes.
    always_comb begin
        w_wordNext = {w_tickCountNext,
                      w_p2StrumsNext,
                      1'b0,
                      w_stableNext[15],
                      w_stableNext[14] | w_stableNext[13],
                      w_stableNext[12:8],
                      w_p1StrumsNext,
                      1'b0,
                      w_stableNext[7],
                      w_stableNext[6] | w_stableNext[5],
                      w_stableNext[4:0]};
    end

    // Counters, prescaler and the output registers. The word is registered
    // so the half-period path into r29 starts directly at a flop.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_p1Strums  <= '0;
            r_p2Strums  <= '0;
            r_prescale  <= '0;
            r_tickCount <= '0;
            r_tickPulse <= 1'b0;
            r_word      <= '0;
        end else begin
            r_p1Strums  <= w_p1StrumsNext;
            r_p2Strums  <= w_p2StrumsNext;
            r_prescale  <= w_prescaleNext;
            r_tickCount <= w_tickCountNext;
            r_tickPulse <= w_tickWrap;
            r_word      <= w_wordNext;
        end
    end

    assign bus.external_inputs = r_word;
    assign bus.tick_pulse      = r_tickPulse;

endmodule

// File: tb/tb_guitar_input_capture.sv
// ---------------------------------------------------------------------------
// tb_guitar_input_capture
//
// Directed bench for guitar_input_capture with DEBOUNCE_CYCLES=4 and
// TICK_CYCLES=10. Stimulus pushes hand-computed expectations, tagged with
// the absolute rising-edge number they apply to, into a scoreboard queue; a
// forked monitor samples {tick_pulse, external_inputs} on every falling edge
// and checks whichever expectations are due.
// ---------------------------------------------------------------------------
module tb_guitar_input_capture;

    localparam int DB = 4;
    localparam int TK = 10;

    localparam logic [32:0] ALL_BITS = {33{1'b1}};
    localparam logic [32:0] PULSE    = 33'h1_0000_0000;
    localparam logic [32:0] TICKF    = 33'h0_FF00_0000;
    localparam logic [32:0] P1FRET   = 33'h0_0000_001F;
    localparam logic [32:0] P1STRUM  = 33'h0_0000_0020;
    localparam logic [32:0] RSV7     = 33'h0_0000_0080;
    localparam logic [32:0] P1CNT    = 33'h0_0000_0F00;
    localparam logic [32:0] P2STRUM  = 33'h0_0002_0000;
    localparam logic [32:0] P2START  = 33'h0_0004_0000;
    localparam logic [32:0] RSV19    = 33'h0_0008_0000;
    localparam logic [32:0] P2CNT    = 33'h0_00F0_0000;

    typedef struct {
        int          cyc;
        logic [32:0] mask;
        logic [32:0] val;
        string       name;
    } exp_t;

    logic clock        = 1'b0;
    logic ctrl_reset_n = 1'b0;
    int   edgeCnt      = 0;
    exp_t sbQ[$];
    int   checks       = 0;
    int   errors       = 0;
    bit   finishReq    = 1'b0;
    bit   monitorDone  = 1'b0;

    guitar_input_capture_if bus ();

    guitar_input_capture #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_CYCLES    (TK)
    ) dut (
        .clock       (clock),
        .ctrl_reset_n(ctrl_reset_n),
        .bus         (bus)
    );

    // Free-running clock and an absolute rising-edge counter used to tag
    // every expectation.
    always #5 clock = ~clock;

    always @(posedge clock) edgeCnt <= edgeCnt + 1;

    // Drive every raw button at once.
    task automatic applyStimulus(input logic [4:0] f1, input logic u1, input logic d1, input logic s1,
                                 input logic [4:0] f2, input logic u2, input logic d2, input logic s2);
        bus.p1_fret       = f1;
        bus.p1_strum_up   = u1;
        bus.p1_strum_down = d1;
        bus.p1_start      = s1;
        bus.p2_fret       = f2;
        bus.p2_strum_up   = u2;
        bus.p2_strum_down = d2;
        bus.p2_start      = s2;
    endtask

    task automatic expectAt(input int cyc, input logic [32:0] mask, input logic [32:0] val,
                            input string name);
        exp_t e;
        e.cyc  = cyc;
        e.mask = mask;
        e.val  = val;
        e.name = name;
        sbQ.push_back(e);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic stepEdges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [32:0] act;
        act = {bus.tick_pulse, bus.external_inputs};
        checks++;
        if ((act & e.mask) !== (e.val & e.mask)) begin
            errors++;
            $display("[TB] FAIL %s @edge %0d: got %h, expected %h (mask %h)",
                     e.name, e.cyc, act & e.mask, e.val & e.mask, e.mask);
        end
    endtask

    // Scoreboard monitor: on each falling edge check all expectations due
    // at the current edge; on request flag whatever was never reached.
    task automatic monitorLoop();
        forever begin
            @(negedge clock);
            for (int i = sbQ.size() - 1; i >= 0; i--) begin
                if (sbQ[i].cyc == edgeCnt) begin
                    checkOutput(sbQ[i]);
                    sbQ.delete(i);
                end else if (sbQ[i].cyc < edgeCnt) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s: expectation for edge %0d not sampled, now edge %0d",
                             sbQ[i].name, sbQ[i].cyc, edgeCnt);
                    sbQ.delete(i);
                end
            end
            if (finishReq && !monitorDone) begin
                foreach (sbQ[i]) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s: expectation for edge %0d still pending at end",
                             sbQ[i].name, sbQ[i].cyc);
                end
                sbQ.delete();
                monitorDone = 1'b1;
            end
        end
    endtask

    // Directed test sequence.
    initial begin
        int          k;
        int          m;
        int          r;
        logic [32:0] v;

        fork
            monitorLoop();
        join_none

        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        ctrl_reset_n = 1'b0;

        // Reset held with inputs toggling: everything stays zero.
        for (int i = 0; i < 8; i++) begin
            stepEdges(1);
            applyStimulus(5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (i == 2 || i == 6) expectAt(edgeCnt, ALL_BITS, 33'h0, "resetHold");
        end
        stepEdges(1);
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        ctrl_reset_n = 1'b1;
        r = edgeCnt;
        for (int j = 1; j <= 9; j++) expectAt(r + j, ALL_BITS, 33'h0, "postResetZero");
        expectAt(r + 10,   ALL_BITS,      33'h1_0100_0000, "firstTick");
        expectAt(r + 11,   PULSE | TICKF, 33'h0_0100_0000, "tickPulseDrop");
        expectAt(r + 2559, PULSE | TICKF, 33'h0_FF00_0000, "tickCount255");
        expectAt(r + 2560, PULSE | TICKF, 33'h1_0000_0000, "tickWrap");
        stepEdges(2561);

        // Fret press and release: D+2 edges of latency each way.
        k = edgeCnt;
        applyStimulus(5'b10101, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        expectAt(k + 5, P1FRET | RSV7 | RSV19, 33'h0,  "fretEarly");
        expectAt(k + 6, P1FRET | RSV7 | RSV19, 33'h15, "fretPress");
        stepEdges(8);
        m = edgeCnt;
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        expectAt(m + 5, P1FRET | RSV7 | RSV19, 33'h15, "fretHeld");
        expectAt(m + 6, P1FRET | RSV7 | RSV19, 33'h0,  "fretRelease");
        stepEdges(8);

        // Bounce on p2_start: 3 high, 1 low, 3 high never qualifies.
        k = edgeCnt;
        expectAt(k + 6,  P2START, 33'h0, "bounce1");
        expectAt(k + 10, P2START, 33'h0, "bounce2");
        expectAt(k + 12, P2START, 33'h0, "bounce3");
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        stepEdges(3);
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        stepEdges(1);
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        stepEdges(3);
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        stepEdges(3);
        k = edgeCnt;
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        expectAt(k + 5, P2START, 33'h0,     "startEarly");
        expectAt(k + 6, P2START, 33'h40000, "startPress");
        stepEdges(6);
        m = edgeCnt;
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        expectAt(m + 5, P2START, 33'h40000, "startHeld");
        expectAt(m + 6, P2START, 33'h0,     "startRelease");
        stepEdges(8);

        // Seventeen clean p1 strums: count 1..15, 0, 1.
        for (int n = 1; n <= 17; n++) begin
            k = edgeCnt;
            applyStimulus(5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            v = 33'((n - 1) % 16) << 8;
            expectAt(k + 5, P1STRUM | P1CNT, v, "strumBefore");
            v = (33'(n % 16) << 8) | 33'h20;
            expectAt(k + 6, P1STRUM | P1CNT, v, "strumCount");
            stepEdges(6);
            m = edgeCnt;
            applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            v = 33'(n % 16) << 8;
            expectAt(m + 6, P1STRUM | P1CNT, v, "strumRelease");
            stepEdges(8);
        end

        // Simultaneous p2 up and down count once.
        k = edgeCnt;
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        expectAt(k + 5, P2STRUM | P2CNT, 33'h0,      "dualBefore");
        expectAt(k + 6, P2STRUM | P2CNT, 33'h120000, "dualStrum");
        expectAt(k + 7, P2STRUM | P2CNT, 33'h120000, "dualNoDouble");
        stepEdges(6);
        m = edgeCnt;
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        expectAt(m + 6, P2STRUM | P2CNT, 33'h100000, "dualRelease");
        stepEdges(8);

        // Reset in the middle of a debounce window, buttons held throughout.
        applyStimulus(5'b00001, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        stepEdges(3);
        ctrl_reset_n = 1'b0;
        expectAt(edgeCnt, ALL_BITS, 33'h0, "midResetClear");
        stepEdges(2);
        expectAt(edgeCnt, ALL_BITS, 33'h0, "midResetHold");
        ctrl_reset_n = 1'b1;
        r = edgeCnt;
        expectAt(r + 5,  P1FRET | P2STRUM | P2CNT | RSV7 | RSV19, 33'h0,        "reDebounceEarly");
        expectAt(r + 6,  P1FRET | P2STRUM | P2CNT | RSV7 | RSV19, 33'h12_0001,  "reDebounce");
        expectAt(r + 9,  P2CNT,                                   33'h100000,   "heldCountOnce");
        expectAt(r + 10, PULSE | TICKF,                           33'h1_0100_0000, "tickAfterReset");
        stepEdges(12);
        applyStimulus(5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        stepEdges(2);

        finishReq = 1'b1;
        repeat (5) begin
            @(negedge clock);
            #1;
            if (monitorDone) break;
        end
        if (!monitorDone) begin
            checks++;
            errors++;
            $display("[TB] FAIL monitorDrain: got not drained, required drained");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
